// File: rtl/inject_ctrl_if.sv
// Local-port bus of one router injection controller: PE flit offer and
// back-pressure, per-slot link occupancy, and the injection/loopback outputs.
interface inject_ctrl_if;
    logic       pe_valid;
    logic [9:0] pe_flit;
    logic       pe_ready;
    logic [3:0] link_busy;
    logic       inj_valid;
    logic [3:0] inj_sel;
    logic [9:0] inj_flit;
    logic       lb_valid;
    logic [9:0] lb_flit;

    // PE / link side: offers flits and reports slot occupancy
    modport master (
        output pe_valid, pe_flit, link_busy,
        input  pe_ready, inj_valid, inj_sel, inj_flit, lb_valid, lb_flit
    );

    // Injection controller side
    modport slave (
        input  pe_valid, pe_flit, link_busy,
        output pe_ready, inj_valid, inj_sel, inj_flit, lb_valid, lb_flit
    );
endinterface

// File: rtl/inject_ctrl.sv
// Router local-port injection controller: queues PE flits in a small FIFO,
// computes the XY direction of the head flit, injects it into the first free
// output slot in round-robin order, or loops it back when it is addressed to
// this router. Optional macro INJ_STARVE_EN adds a registered starvation flag
// raised after STARVE_LIMIT consecutive cycles with every slot busy.
module inject_ctrl #(
    parameter logic [2:0] ROW          = 3'd4,
    parameter logic [2:0] COL          = 3'd4,
    parameter int         DEPTH        = 4,
    parameter int         STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    inject_ctrl_if.slave bus
`ifdef INJ_STARVE_EN
    ,
    output logic         starve
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    // Only the golden bit and the address are stored; the direction field
    // is recomputed from the address at the head.
    logic [6:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, pop;
    logic [6:0]  head;
    logic [2:0]  dir;
    logic        is_local;
    logic [1:0]  rr_ptr, scan_idx, grant_idx;
    logic [3:0]  grant_sel;
    logic        found;
    state_t      state_q, state_d;
    logic        unused_dir_bits;

    assign unused_dir_bits = ^bus.pe_flit[8:6];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.pe_valid && !full && !rst;
    assign head  = mem[rd_ptr[AW-1:0]];

    // XY routing: resolve column first, then row; equal on both is local
    always_comb begin
        dir = 3'b100;
        if (head[2:0] > COL)      dir = 3'b000;
        else if (head[2:0] < COL) dir = 3'b001;
        else if (head[5:3] > ROW) dir = 3'b010;
        else if (head[5:3] < ROW) dir = 3'b011;
    end

    assign is_local = (dir == 3'b100);

    // Round-robin scan for the first free slot starting at rr_ptr
    always_comb begin
        found     = 1'b0;
        grant_idx = 2'd0;
        grant_sel = 4'b0000;
        scan_idx  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr + 2'(i);
            if (!found && !bus.link_busy[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
                grant_sel = 4'b0001 << scan_idx;
            end
        end
    end

    // Outputs are forced quiet while reset is asserted so nothing leaves in the reset cycle
    assign bus.inj_valid = !rst && !empty && !is_local && found;
    assign bus.lb_valid  = !rst && !empty && is_local;
    assign bus.inj_sel   = bus.inj_valid ? grant_sel : 4'b0000;
    assign bus.inj_flit  = bus.inj_valid ? {head[6], dir, head[5:0]} : 10'd0;
    assign bus.lb_flit   = bus.lb_valid ? {head[6], 3'b100, head[5:0]} : 10'd0;
    assign bus.pe_ready  = !full;
    assign pop           = bus.inj_valid || bus.lb_valid;

    // FIFO storage, data only
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {bus.pe_flit[9], bus.pe_flit[5:0]};
    end

    // FIFO pointers; reset discards everything queued
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Round-robin pointer moves just past the slot that was granted
    always_ff @(posedge clk) begin
        if (rst)                rr_ptr <= 2'd0;
        else if (bus.inj_valid) rr_ptr <= grant_idx + 2'd1;
    end

    // Classify the current cycle: empty, head leaving, or head blocked
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = pop ? SEND : WAIT;
            WAIT:    if (pop) state_d = SEND;
                     else if (empty) state_d = IDLE;
            SEND:    if (empty) state_d = IDLE;
                     else state_d = pop ? SEND : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

`ifdef INJ_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] wait_cnt;

    // Count blocked cycles of the current head; flag starvation as the count reaches the limit
    always_ff @(posedge clk) begin
        if (rst || pop) begin
            wait_cnt <= '0;
            starve   <= 1'b0;
        end else if (state_d == WAIT) begin
            if (wait_cnt < CW'(STARVE_LIMIT))     wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= CW'(STARVE_LIMIT - 1)) starve  <= 1'b1;
        end
    end
`else
    localparam int unused_starve_limit = STARVE_LIMIT;
`endif
endmodule

// File: tb/tb_inject_ctrl.sv
// Bench for inject_ctrl (ROW=COL=4, DEPTH=4): a vector table of single-flit
// transfers plus hand-written sequences for round-robin, back-pressure,
// mid-stream reset and, with INJ_STARVE_EN, starvation.
module tb_inject_ctrl;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    inject_ctrl_if bus();
`ifdef INJ_STARVE_EN
    logic starve;
`endif

    inject_ctrl #(.ROW(3'd4), .COL(3'd4), .DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef INJ_STARVE_EN
        ,
        .starve (starve)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lb;
        logic [3:0] sel;
        logic [9:0] flit;
    } exp_t;

    typedef struct {
        logic [9:0] flit;
        logic [3:0] busy;
        logic       lb;
        logic [3:0] sel;
        logic [9:0] oflit;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Compare any output event against the oldest scoreboard entry
    task automatic monitor();
        exp_t        e;
        logic [25:0] act, req;
        if (bus.inj_valid || bus.lb_valid) begin
            checks++;
            act = {bus.inj_valid, bus.lb_valid, bus.inj_sel, bus.inj_flit, bus.lb_flit};
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h expected no output", act);
            end else begin
                e = sb_q.pop_front();
                if (e.lb) req = {1'b0, 1'b1, 4'b0000, 10'd0, e.flit};
                else      req = {1'b1, 1'b0, e.sel, e.flit, 10'd0};
                if (act !== req) begin
                    errors++;
                    $display("FAIL sb_out: got %h expected %h", act, req);
                end
            end
        end
    endtask

    // One clock: sample mid-cycle, then return just after the rising edge
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.pe_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.pe_valid  = 1'b0;
        bus.pe_flit   = 10'd0;
        bus.link_busy = 4'h0;
        @(posedge clk);
        #1;
        chk("rst_pe_ready",  32'(bus.pe_ready),  32'd1);
        chk("rst_inj_valid", 32'(bus.inj_valid), 32'd0);
        chk("rst_inj_sel",   32'(bus.inj_sel),   32'd0);
        chk("rst_inj_flit",  32'(bus.inj_flit),  32'd0);
        chk("rst_lb_valid",  32'(bus.lb_valid),  32'd0);
        chk("rst_lb_flit",   32'(bus.lb_flit),   32'd0);
        rst = 1'b0;

        // flit, link_busy, loopback, expected slot, expected output flit
        vecs[0] = '{10'h02F, 4'b0000, 1'b0, 4'b0001, 10'h02F};
        vecs[1] = '{10'h020, 4'b0000, 1'b0, 4'b0010, 10'h060};
        vecs[2] = '{10'h23C, 4'b0100, 1'b0, 4'b1000, 10'h2BC};
        vecs[3] = '{10'h00C, 4'b0001, 1'b0, 4'b0010, 10'h0CC};
        vecs[4] = '{10'h1E2, 4'b1011, 1'b0, 4'b0100, 10'h062};
        vecs[5] = '{10'h024, 4'b1111, 1'b1, 4'b0000, 10'h124};
        vecs[6] = '{10'h3E4, 4'b0000, 1'b1, 4'b0000, 10'h324};
        vecs[7] = '{10'h005, 4'b1110, 1'b0, 4'b0001, 10'h005};
        vecs[8] = '{10'h02F, 4'b0101, 1'b0, 4'b0010, 10'h02F};

        for (int i = 0; i < 9; i++) begin
            bus.pe_valid  = 1'b1;
            bus.pe_flit   = vecs[i].flit;
            bus.link_busy = vecs[i].busy;
            sb_q.push_back('{vecs[i].lb, vecs[i].sel, vecs[i].oflit});
            cycle();
            bus.pe_valid = 1'b0;
            cycle();
        end
        cycle();
        chk("table_drained", 32'(sb_q.size()), 32'd0);
        chk("table_empty_ready", 32'(bus.pe_ready), 32'd1);

        // Back-to-back westbound flits rotate through all four slots
        do_reset();
        bus.link_busy = 4'h0;
        for (int k = 0; k < 4; k++) begin
            bus.pe_valid = 1'b1;
            bus.pe_flit  = 10'h020;
            sb_q.push_back('{1'b0, 4'b0001 << k, 10'h060});
            cycle();
        end
        bus.pe_valid = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("rr_drained", 32'(sb_q.size()), 32'd0);

        // Fill with all slots busy, then free only the south slot
        do_reset();
        bus.link_busy = 4'hF;
        bus.pe_valid  = 1'b1;
        bus.pe_flit   = 10'h02F;
        for (int k = 0; k < DEPTH; k++) begin
            chk("fill_ready", 32'(bus.pe_ready), 32'd1);
            cycle();
        end
        chk("full_not_ready", 32'(bus.pe_ready), 32'd0);
        cycle();
        chk("full_held_not_ready", 32'(bus.pe_ready), 32'd0);
        chk("full_no_inject", 32'(bus.inj_valid), 32'd0);
        bus.pe_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) sb_q.push_back('{1'b0, 4'b1000, 10'h02F});
        bus.link_busy = 4'h7;
        for (int k = 0; k < DEPTH + 2; k++) cycle();
        chk("full_drained", 32'(sb_q.size()), 32'd0);
        chk("full_ready_again", 32'(bus.pe_ready), 32'd1);

        // Reset with three flits queued: none may ever come out
        do_reset();
        bus.link_busy = 4'hF;
        bus.pe_valid  = 1'b1;
        bus.pe_flit   = 10'h02F;
        for (int k = 0; k < 3; k++) cycle();
        bus.pe_valid  = 1'b0;
        rst           = 1'b1;
        bus.link_busy = 4'h0;
        cycle();
        rst = 1'b0;
        chk("midrst_pe_ready",  32'(bus.pe_ready),  32'd1);
        chk("midrst_inj_valid", 32'(bus.inj_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk("midrst_quiet", 32'(bus.inj_valid), 32'd0);
            cycle();
        end

`ifdef INJ_STARVE_EN
        // One blocked flit: starvation flag after eight waiting cycles, cleared by the pop
        do_reset();
        bus.link_busy = 4'hF;
        bus.pe_valid  = 1'b1;
        bus.pe_flit   = 10'h02F;
        cycle();
        bus.pe_valid = 1'b0;
        for (int k = 0; k < 7; k++) cycle();
        chk("starve_before_limit", 32'(starve), 32'd0);
        cycle();
        chk("starve_at_limit", 32'(starve), 32'd1);
        cycle();
        cycle();
        chk("starve_held", 32'(starve), 32'd1);
        sb_q.push_back('{1'b0, 4'b0001, 10'h02F});
        bus.link_busy = 4'h0;
        chk("starve_pop_cycle", 32'(starve), 32'd1);
        cycle();
        chk("starve_cleared", 32'(starve), 32'd0);
        chk("starve_drained", 32'(sb_q.size()), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inject_ctrl.md
INJECT_CTRL -- requirements
Module: inject_ctrl

Interface
REQ-001 Parameter ROW, default 3'd4, row coordinate of this router.
REQ-002 Parameter COL, default 3'd4, column coordinate of this router.
REQ-003 Parameter DEPTH, default 4, local flit FIFO entries (power of two, 2..16).
REQ-004 Parameter STARVE_LIMIT, default 8, wait cycles before starvation is flagged.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 pe_valid  input  1  PE offers a flit.
REQ-008 pe_flit  input  10  [9] golden, [8:6] ignored, [5:3] dest row, [2:0] dest col.
REQ-009 pe_ready  output  1  FIFO can accept; transfer when pe_valid&pe_ready.
REQ-010 link_busy  input  4  per output slot occupied this cycle; bit 0 E, 1 W, 2 N, 3 S.
REQ-011 inj_valid  output  1  a flit is injected this cycle.
REQ-012 inj_sel  output  4  one-hot slot receiving inj_flit; zero when inj_valid=0.
REQ-013 inj_flit  output  10  FIFO head with [8:6] replaced by computed direction.
REQ-014 lb_valid  output  1  head flit addressed to this router, returned to PE.
REQ-015 lb_flit  output  10  loopback flit, direction field 3'b100.
REQ-016 starve  output  1  injection starved (present only under INJ_STARVE_EN).

Function
REQ-017 Direction of head: dcol>COL 000 E; dcol<COL 001 W; dcol==COL and drow>ROW 010 N; drow<ROW 011 S; both equal 100 local.
REQ-018 FIFO write on pe_valid&pe_ready; pe_ready = not full; no write when full, flit held by PE.
REQ-019 Simultaneous push and pop when full is not permitted (pe_ready low); when neither empty nor full both occur in one cycle, count unchanged.
REQ-020 Free slots = ~link_busy; inj_valid = non-empty & head not local & any free slot, combinational in same cycle.
REQ-021 Slot choice round-robin: first free slot at or after rr_ptr, scanning E,W,N,S, wrapping.
REQ-022 On grant, rr_ptr <= granted index+1 mod 4 next cycle; unchanged otherwise.
REQ-023 Head is popped in the cycle inj_valid or lb_valid is high; one flit per cycle maximum.
REQ-024 Local-destined head: lb_valid=1 regardless of link_busy; inj_valid=0.
REQ-025 FSM states IDLE (empty), SEND (head granted this cycle), WAIT (head present, all slots busy).
REQ-026 IDLE->SEND/WAIT when FIFO becomes non-empty; WAIT->SEND when any slot frees; SEND->IDLE if FIFO empties, else SEND/WAIT per next head.
REQ-027 Wait counter increments each WAIT cycle, saturates at STARVE_LIMIT, clears on any pop.
REQ-028 Golden bit [9] and address [5:0] pass unchanged to inj_flit/lb_flit.

Reset
REQ-029 On rst: FIFO empty, pe_ready=1, inj_valid=0, inj_sel=4'b0000, inj_flit=10'd0, lb_valid=0, lb_flit=10'd0, rr_ptr=0 (E), state IDLE, wait counter 0, starve=0.
REQ-030 rst asserted mid-operation discards all queued flits; no injection in the reset cycle.

Configuration
REQ-031 Macro INJ_STARVE_EN defined: starve registered, set when wait counter reaches STARVE_LIMIT, cleared cycle after the pop.
REQ-032 INJ_STARVE_EN undefined: starve port and wait counter absent; behaviour otherwise identical.

Verification
REQ-033 ROW=COL=4, push 10'h02F (row5 col7), link_busy=0 -> next cycle inj_valid=1, inj_sel=0001, inj_flit=10'h02F with [8:6]=000.
REQ-034 Push 4 flits dest col 0, link_busy=0 held -> inj_sel sequence 0001,0010,0100,1000, all [8:6]=001.
REQ-035 Push DEPTH+1 flits, link_busy=4'hF -> pe_ready=0 after DEPTH writes, no inj_valid; release to 4'h7 -> inj_sel=1000.
REQ-036 Push 10'h024 (row4 col4) with link_busy=4'hF -> lb_valid=1, lb_flit[8:6]=100, inj_valid=0, FIFO empties.
REQ-037 INJ_STARVE_EN, STARVE_LIMIT=8, one flit, link_busy=4'hF for 10 cycles -> starve=1 from 8th WAIT cycle, 0 after pop.
REQ-038 Assert rst with 3 queued flits -> next cycle pe_ready=1, inj_valid=0, no queued flit ever injected.
